muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage. Consumes the two register-file read ports (RD1/RD2) as operands and produces a 32-bit result plus destination index for the register-file write port (WD3/AD3/WE3). Runs at a fixed 34-cycle latency with a start/busy/done handshake, so the pipeline stalls on `busy`.

## Interface
- `XLEN`, default 32: operand/result width. Only 32 is supported.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset rst, synchronous, active-high.
- `start` in 1: request; accepted only when `busy`=0.
- `funct3` in 3: RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a` in 32: rs1 value (RD1).
- `op_b` in 32: rs2 value (RD2).
- `rd_in` in 5: destination register index.
- `busy` out 1: operation in flight.
- `done` out 1: one-cycle pulse; `result`/`rd_out` valid.
- `result` out 32: operation result, held until the next accepted start.
- `rd_out` out 5: captured `rd_in`, drives AD3.
- `wb_we` out 1: equals `done`, drives WE3.

## Operation
- States: IDLE, CALC, FIX.
- IDLE: if `start`=1, capture `funct3`, `rd_in`, operand signs and magnitudes. Clear the 6-bit iteration counter and the 64-bit accumulator. Go to CALC. `op_a`/`op_b` are not used after the accept edge.
- CALC: one radix-2 step per cycle.
  - Multiply: shift-add of the 32-bit magnitudes into the 64-bit product.
  - Divide: restoring step producing one quotient bit, with a 33-bit partial remainder.
  - After the 32nd step, go to FIX.
- FIX: apply sign correction and special cases, select the output word, register `result` and `rd_out`, pulse `done`, then go to IDLE.
- Signedness:
  - MULH: both operands signed. MULHSU: `op_a` signed, `op_b` unsigned. MULHU, DIVU, REMU: both unsigned. MUL: low word is sign-agnostic.
  - DIV/REM: both operands signed.
- Product: negate the 64-bit product if the operand signs differ. MUL returns bits [31:0]; the MULH variants return bits [63:32].
- Quotient sign is sa XOR sb. Remainder takes the sign of `op_a`.
- Divide by zero (any signedness): quotient = 0xFFFFFFFF, remainder = `op_a`.
- Signed overflow (0x80000000 / 0xFFFFFFFF): DIV = 0x80000000, REM = 0.
- Special cases still take the full latency. There is no early termination.
- `start` while `busy`=1 is ignored. Captured operands and `rd` are not disturbed.
- `rd_in`=0 still completes normally. The register file drops writes to x0.

## Timing
- Reset values: `busy`=0, `done`=0, `wb_we`=0, `result`=0, `rd_out`=0, state IDLE, counter 0.
- Start accepted at edge k.
  - `busy`=1 from edge k through edge k+33.
  - CALC occupies edges k+1 to k+32. FIX occupies edge k+33.
  - At edge k+34, `busy` falls and `done`/`wb_we` rise for exactly one cycle.
- Latency is 34 cycles, start-accept to done.
- During the `done` cycle the state is IDLE, so a new `start` may be accepted back-to-back. Its `done` follows 34 cycles later.
- `result` and `rd_out` change only at FIX and remain stable after `done` falls.
- All outputs are registered on the rising edge. The register file's falling-edge write therefore captures `result`/`rd_out`/`wb_we` within the `done` cycle.
- `rst` asserted at any edge, including mid-CALC or mid-FIX: all outputs and state return to reset values at that edge. No `done` is produced for the aborted operation. A `start` in the same cycle as `rst` is dropped.

## Test plan
- MUL 7 × 6, `rd_in`=5 -> `done` exactly 34 cycles after accept; `result`=42, `rd_out`=5, `wb_we`=1 for exactly one cycle.
- MULH / MULHSU / MULHU with `op_a`=0xFFFFFFFF, `op_b`=0xFFFFFFFF -> 0x00000000 / 0xFFFFFFFF / 0xFFFFFFFE. MUL of the same operands -> 0x00000001.
- DIV −7/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 7/2 -> 3; REMU -> 1.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0. DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5. Latency is 34 in all cases.
- `start` pulsed again at cycle 10 of a busy op with different operands -> ignored, first result unaffected. A new `start` in the `done` cycle -> accepted, second `done` 34 cycles later.
- `rst` at cycle 20 of a DIV -> `busy`=0, `done` never pulses for it, `result`=0, `rd_out`=0. The next op after reset completes normally.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Handshake and operand/result bundle between the execute stage and muldiv_unit.
interface muldiv_unit_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [4:0]      rd_in;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   logic [4:0]      rd_out;
   logic            wb_we;

   modport master (
      output start, funct3, op_a, op_b, rd_in,
      input  busy, done, result, rd_out, wb_we
   );

   modport slave (
      input  start, funct3, op_a, op_b, rd_in,
      output busy, done, result, rd_out, wb_we
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: magnitude shift-add / restoring divide,
// sign fix-up at the end, fixed 34-cycle start-to-done latency.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input logic          clk,
   input logic          rst,
   muldiv_unit_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t            state, state_n;
   logic [5:0]        cnt, cnt_n;
   logic [2:0]        f3, f3_n;
   logic [4:0]        rd_q, rd_q_n;
   logic              sa, sa_n, sb, sb_n, b_zero, b_zero_n;
   logic [XLEN-1:0]   ma, ma_n, mb, mb_n;
   logic [2*XLEN-1:0] acc, acc_n;
   logic [XLEN-1:0]   prem, prem_n;
   logic              busy_q, busy_n, done_q, done_n;
   logic [XLEN-1:0]   result_q, result_n;
   logic [4:0]        rd_out_q, rd_out_n;

   logic              signed_a, signed_b;
   logic [XLEN:0]     sum, trial;
   logic [XLEN-1:0]   sub;
   logic              ge;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quot_s, rem_s;

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.wb_we  = done_q;
   assign bus.result = result_q;
   assign bus.rd_out = rd_out_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         f3       <= '0;
         rd_q     <= '0;
         sa       <= 1'b0;
         sb       <= 1'b0;
         b_zero   <= 1'b0;
         ma       <= '0;
         mb       <= '0;
         acc      <= '0;
         prem     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         rd_out_q <= '0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         f3       <= f3_n;
         rd_q     <= rd_q_n;
         sa       <= sa_n;
         sb       <= sb_n;
         b_zero   <= b_zero_n;
         ma       <= ma_n;
         mb       <= mb_n;
         acc      <= acc_n;
         prem     <= prem_n;
         busy_q   <= busy_n;
         done_q   <= done_n;
         result_q <= result_n;
         rd_out_q <= rd_out_n;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      f3_n     = f3;
      rd_q_n   = rd_q;
      sa_n     = sa;
      sb_n     = sb;
      b_zero_n = b_zero;
      ma_n     = ma;
      mb_n     = mb;
      acc_n    = acc;
      prem_n   = prem;
      busy_n   = busy_q;
      done_n   = 1'b0;
      result_n = result_q;
      rd_out_n = rd_out_q;

      signed_a = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                 (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
      signed_b = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                 (bus.funct3 == 3'b110);

      sum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (mb[0] ? ma : '0)};
      trial  = {prem, ma[XLEN-1]};
      ge     = (trial >= {1'b0, mb});
      // When ge holds the difference is below mb, so the low XLEN bits suffice.
      sub    = trial[XLEN-1:0] - mb;
      prod_s = (sa ^ sb) ? -acc : acc;
      quot_s = b_zero ? '1 : ((sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0]);
      rem_s  = sa ? -prem : prem;

      case (state)
         IDLE: begin
            if (bus.start) begin
               f3_n     = bus.funct3;
               rd_q_n   = bus.rd_in;
               sa_n     = signed_a & bus.op_a[XLEN-1];
               sb_n     = signed_b & bus.op_b[XLEN-1];
               ma_n     = sa_n ? -bus.op_a : bus.op_a;
               mb_n     = sb_n ? -bus.op_b : bus.op_b;
               b_zero_n = (bus.op_b == '0);
               cnt_n    = '0;
               acc_n    = '0;
               prem_n   = '0;
               busy_n   = 1'b1;
               state_n  = CALC;
            end
         end
         CALC: begin
            if (cnt == 6'(XLEN)) begin
               state_n = FIX;
            end else begin
               cnt_n = cnt + 6'd1;
               if (f3[2]) begin
                  prem_n = ge ? sub : trial[XLEN-1:0];
                  ma_n   = {ma[XLEN-2:0], 1'b0};
                  acc_n  = {acc[2*XLEN-2:0], ge};
               end else begin
                  acc_n = {sum, acc[XLEN-1:1]};
                  mb_n  = {1'b0, mb[XLEN-1:1]};
               end
            end
         end
         FIX: begin
            if (!f3[2])
               result_n = (f3[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
            else
               result_n = f3[1] ? rem_s : quot_s;
            rd_out_n = rd_q;
            done_n   = 1'b1;
            busy_n   = 1'b0;
            state_n  = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// Table-driven bench for muldiv_unit with a scoreboard checked on every done pulse.
module tb_muldiv_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   logic prev_done = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   muldiv_unit_if #(.XLEN(32)) bus ();
   muldiv_unit #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      int          acc_cyc;
   } exp_t;

   vec_t vecs[$];
   exp_t sb_q[$];
   logic [31:0] last_exp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Called at a falling edge; the request is accepted at the next rising edge.
   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp);
      exp_t e;
      bus.start  = 1'b1;
      bus.funct3 = f3;
      bus.op_a   = a;
      bus.op_b   = b;
      bus.rd_in  = rd;
      e.res = exp;
      e.rd = rd;
      e.acc_cyc = cyc + 1;
      sb_q.push_back(e);
      last_exp = exp;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_timeout: got no done, required done within %0d cycles", budget);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (prev_done) check("done_width", {31'b0, bus.done}, 32'd0);
         if (bus.done) begin
            if (sb_q.size() == 0) begin
               check("spurious_done", {31'b0, bus.done}, 32'd0);
            end else begin
               e = sb_q.pop_front();
               check("result", bus.result, e.res);
               check("rd_out", {27'b0, bus.rd_out}, {27'b0, e.rd});
               check("wb_we", {31'b0, bus.wb_we}, 32'd1);
               check("latency", 32'(cyc - e.acc_cyc), 32'd34);
            end
         end
      end
      prev_done = bus.done;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish, required finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs.push_back('{3'b000, 32'd7,        32'd6,        5'd5,  32'd42});
      vecs.push_back('{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'h00000000});
      vecs.push_back('{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFF});
      vecs.push_back('{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE});
      vecs.push_back('{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'h00000001});
      vecs.push_back('{3'b001, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000});
      vecs.push_back('{3'b010, 32'h80000000, 32'd2,        5'd7,  32'hFFFFFFFF});
      vecs.push_back('{3'b001, 32'd3,        32'hFFFFFFFE, 5'd8,  32'hFFFFFFFF});
      vecs.push_back('{3'b000, 32'd3,        32'hFFFFFFFE, 5'd9,  32'hFFFFFFFA});
      vecs.push_back('{3'b100, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD});
      vecs.push_back('{3'b110, 32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF});
      vecs.push_back('{3'b101, 32'd7,        32'd2,        5'd12, 32'd3});
      vecs.push_back('{3'b111, 32'd7,        32'd2,        5'd13, 32'd1});
      vecs.push_back('{3'b100, 32'd7,        32'hFFFFFFFE, 5'd14, 32'hFFFFFFFD});
      vecs.push_back('{3'b110, 32'd7,        32'hFFFFFFFE, 5'd15, 32'd1});
      vecs.push_back('{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000});
      vecs.push_back('{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'd0});
      vecs.push_back('{3'b101, 32'd5,        32'd0,        5'd18, 32'hFFFFFFFF});
      vecs.push_back('{3'b111, 32'd5,        32'd0,        5'd19, 32'd5});
      vecs.push_back('{3'b100, 32'hFFFFFFF9, 32'd0,        5'd20, 32'hFFFFFFFF});
      vecs.push_back('{3'b110, 32'hFFFFFFF9, 32'd0,        5'd0,  32'hFFFFFFF9});

      // Reset with start held high: the request must be dropped.
      bus.start = 1'b1;
      bus.funct3 = 3'b000;
      bus.op_a = 32'd1;
      bus.op_b = 32'd1;
      bus.rd_in = 5'd1;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'b0, bus.busy}, 32'd0);
      check("rst_done", {31'b0, bus.done}, 32'd0);
      check("rst_wb_we", {31'b0, bus.wb_we}, 32'd0);
      check("rst_result", bus.result, 32'd0);
      check("rst_rd_out", {27'b0, bus.rd_out}, 32'd0);
      rst = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);
      check("post_rst_busy", {31'b0, bus.busy}, 32'd0);

      foreach (vecs[i]) begin
         @(negedge clk);
         issue(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp);
         wait_done(40);
      end

      repeat (3) @(negedge clk);
      check("result_hold", bus.result, last_exp);

      // Start pulsed while busy must be ignored.
      @(negedge clk);
      issue(3'b000, 32'd7, 32'd6, 5'd5, 32'd42);
      repeat (9) @(negedge clk);
      check("busy_mid_op", {31'b0, bus.busy}, 32'd1);
      bus.start = 1'b1;
      bus.funct3 = 3'b101;
      bus.op_a = 32'd100;
      bus.op_b = 32'd3;
      bus.rd_in = 5'd9;
      @(posedge clk);
      #1 bus.start = 1'b0;
      wait_done(40);

      // Back-to-back: new start in the done cycle.
      @(negedge clk);
      issue(3'b000, 32'd1000, 32'd1000, 5'd7, 32'd1000000);
      wait_done(40);
      issue(3'b111, 32'd100, 32'd7, 5'd8, 32'd2);
      wait_done(40);

      // Reset mid-divide aborts the operation with no done.
      @(negedge clk);
      issue(3'b100, 32'd1000, 32'd3, 5'd21, 32'd333);
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy", {31'b0, bus.busy}, 32'd0);
      check("abort_done", {31'b0, bus.done}, 32'd0);
      check("abort_result", bus.result, 32'd0);
      check("abort_rd_out", {27'b0, bus.rd_out}, 32'd0);
      rst = 1'b0;
      sb_q.delete();
      repeat (40) @(negedge clk);
      check("abort_still_idle", {31'b0, bus.busy}, 32'd0);

      @(negedge clk);
      issue(3'b101, 32'd1000, 32'd3, 5'd22, 32'd333);
      wait_done(40);
      repeat (2) @(negedge clk);
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
